// File: rtl/ysyx_23060332_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_ifu -- multi-cycle instruction fetch unit
//
// Owns the architectural PC. Issues one AXI4-Lite-style read (AR/R) per
// instruction, presents the fetched word to decode via inst_valid/inst_ready,
// then waits for the execute stage's commit before advancing the PC,
// either sequentially (pc+4, wrapping) or to a word-aligned jump target.
//
// Parameters:
//   ADDR_W   : PC / memory address width
//   INST_W   : instruction width
//   RESET_PC : PC value loaded on reset
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   arvalid, arready, araddr      : read address channel (araddr == pc)
//   rvalid, rready, rdata, rresp  : read data channel (rresp != 0 -> error)
//   inst_valid, inst_ready, inst  : instruction handshake to decode
//   pc                            : address of the presented instruction
//   commit_valid, jump_en,
//   jump_addr                     : commit / redirect from execute
//   fetch_err                     : one-cycle pulse on a read error response
//   misalign                      : one-cycle pulse on a misaligned jump target
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module ysyx_23060332_ifu #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           INST_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  // read address channel
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  // read data channel
  input  logic              rvalid,
  output logic              rready,
  input  logic [INST_W-1:0] rdata,
  input  logic [1:0]        rresp,
  // decode interface
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  // commit interface
  input  logic              commit_valid,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  // status pulses
  output logic              fetch_err,
  output logic              misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_inst_valid;
  logic              r_fetch_err;
  logic              r_misalign;

  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_inst_hs;
  logic              w_commit;
  logic              w_resp_err;
  logic              w_jump_misaligned;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [INST_W-1:0] w_inst_nxt;

  // Handshakes are qualified by the registered valid/ready outputs rather than
  // by r_state alone: right after reset r_state is S_REQ but arvalid is still
  // low, and no address may be accepted in that cycle.
  always_comb begin
    w_ar_hs           = r_arvalid & arready;
    w_r_hs            = r_rready & rvalid;
    w_inst_hs         = r_inst_valid & inst_ready;
    w_commit          = (r_state == S_EXEC) & commit_valid;
    w_resp_err        = (rresp != 2'b00);
    w_jump_misaligned = (jump_addr[1:0] != 2'b00);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_ar_hs)   w_state_nxt = S_RESP;
      S_RESP:  if (w_r_hs)    w_state_nxt = S_HOLD;
      S_HOLD:  if (w_inst_hs) w_state_nxt = S_EXEC;
      S_EXEC:  if (w_commit)  w_state_nxt = S_REQ;
      default:                w_state_nxt = S_REQ;
    endcase
  end

  // Next PC on commit: jump targets are forced to word alignment; sequential
  // advance wraps naturally modulo 2^ADDR_W.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_commit) begin
      if (jump_en) w_pc_nxt = {jump_addr[ADDR_W-1:2], 2'b00};
      else         w_pc_nxt = r_pc + ADDR_W'(4);
    end
  end

  // Error responses substitute a NOP so the pipeline keeps flowing.
  always_comb begin
    w_inst_nxt = r_inst;
    if (w_r_hs) w_inst_nxt = w_resp_err ? NOP_INST : rdata;
  end

  // State register and registered outputs. The channel strobes are decoded
  // from the next state so each one is a flop output aligned with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_arvalid    <= (w_state_nxt == S_REQ);
      r_rready     <= (w_state_nxt == S_RESP);
      r_inst_valid <= (w_state_nxt == S_HOLD);
      r_fetch_err  <= w_r_hs & w_resp_err;
      r_misalign   <= w_commit & jump_en & w_jump_misaligned;
    end
  end

  assign arvalid    = r_arvalid;
  assign araddr     = r_pc;
  assign rready     = r_rready;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign pc         = r_pc;
  assign fetch_err  = r_fetch_err;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060332_ifu. Each record holds the inputs driven for one
// clock cycle and the outputs expected to be visible during that same cycle
// (outputs are registered, so they reflect the previous edge).
// ---------------------------------------------------------------------------
module tb_ysyx_23060332_ifu;

  // ctl = {arvalid, rready, inst_valid, fetch_err, misalign}
  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_AR   = 5'b10000;
  localparam logic [4:0] C_R    = 5'b01000;
  localparam logic [4:0] C_V    = 5'b00100;
  localparam logic [4:0] C_E    = 5'b00010;
  localparam logic [4:0] C_M    = 5'b00001;

  typedef struct {
    logic        rst;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        inst_ready;
    logic        commit_valid;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [4:0]  ctl;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc;
  logic        commit_valid, jump_en;
  logic [31:0] jump_addr;
  logic        fetch_err, misalign;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060332_ifu #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rresp       (rresp),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .pc          (pc),
    .commit_valid(commit_valid),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .fetch_err   (fetch_err),
    .misalign    (misalign)
  );

  function automatic vec_t mk(input logic r, input logic ar, input logic rv,
                              input logic [31:0] rd, input logic [1:0] rr,
                              input logic ir, input logic cv, input logic je,
                              input logic [31:0] ja, input logic [4:0] ctl,
                              input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rst = r; v.arready = ar; v.rvalid = rv; v.rdata = rd; v.rresp = rr;
    v.inst_ready = ir; v.commit_valid = cv; v.jump_en = je; v.jump_addr = ja;
    v.ctl = ctl; v.pc = epc; v.inst = einst;
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag, input int idx);
    logic [4:0] got_ctl;
    @(negedge clk);
    rst = v.rst; arready = v.arready; rvalid = v.rvalid; rdata = v.rdata;
    rresp = v.rresp; inst_ready = v.inst_ready; commit_valid = v.commit_valid;
    jump_en = v.jump_en; jump_addr = v.jump_addr;
    #1;
    got_ctl = {arvalid, rready, inst_valid, fetch_err, misalign};
    n_vec++;
    if (got_ctl !== v.ctl || araddr !== v.pc || pc !== v.pc || inst !== v.inst) begin
      n_bad++;
      $display("FAIL %s[%0d]: got ctl=%b araddr=%h pc=%h inst=%h, expected ctl=%b araddr=pc=%h inst=%h",
               tag, idx, got_ctl, araddr, pc, inst, v.ctl, v.pc, v.inst);
    end
  endtask

  vec_t tbl[21];

  initial begin
    // Back-to-back fetches, a misaligned jump, an error response with an
    // out-of-EXEC jump request that must be ignored, then an aligned jump.
    tbl[0]  = mk(1,1,1,32'h93,2'd0,1,1,0,32'h0,        C_IDLE,    32'h8000_0000, 32'h0);
    tbl[1]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_IDLE,    32'h8000_0000, 32'h0);
    tbl[2]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_AR,      32'h8000_0000, 32'h0);
    tbl[3]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_R,       32'h8000_0000, 32'h0);
    tbl[4]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_V,       32'h8000_0000, 32'h93);
    tbl[5]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_IDLE,    32'h8000_0000, 32'h93);
    tbl[6]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_AR,      32'h8000_0004, 32'h93);
    tbl[7]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_R,       32'h8000_0004, 32'h93);
    tbl[8]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_V,       32'h8000_0004, 32'h93);
    tbl[9]  = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_IDLE,    32'h8000_0004, 32'h93);
    tbl[10] = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_AR,      32'h8000_0008, 32'h93);
    tbl[11] = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_R,       32'h8000_0008, 32'h93);
    tbl[12] = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_V,       32'h8000_0008, 32'h93);
    tbl[13] = mk(0,1,1,32'h93,2'd0,1,1,1,32'h8000_0102,C_IDLE,    32'h8000_0008, 32'h93);
    tbl[14] = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_AR|C_M,  32'h8000_0100, 32'h93);
    tbl[15] = mk(0,1,1,32'hDEADBEEF,2'd2,1,1,1,32'h1234_5677,C_R, 32'h8000_0100, 32'h93);
    tbl[16] = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_V|C_E,   32'h8000_0100, 32'h13);
    tbl[17] = mk(0,1,1,32'h93,2'd0,1,1,1,32'h8000_0200,C_IDLE,    32'h8000_0100, 32'h13);
    tbl[18] = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_AR,      32'h8000_0200, 32'h13);
    tbl[19] = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_R,       32'h8000_0200, 32'h13);
    tbl[20] = mk(0,1,1,32'h93,2'd0,1,1,0,32'h0,        C_V,       32'h8000_0200, 32'h93);

    rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    inst_ready = 1'b0; commit_valid = 1'b0; jump_en = 1'b0; jump_addr = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 21; i++) step(tbl[i], "tbl", i);

    // DUT now in EXEC at 80000200. Sequential commit, then AR stall 3 cycles.
    step(mk(0,0,0,32'h0,2'd0,1,1,0,32'h0, C_IDLE, 32'h8000_0200, 32'h93), "commit_seq", 0);
    for (int i = 0; i < 3; i++)
      step(mk(0,0,0,32'h0,2'd0,1,0,0,32'h0, C_AR, 32'h8000_0204, 32'h93), "ar_stall", i);
    step(mk(0,1,0,32'h0,2'd0,1,0,0,32'h0, C_AR, 32'h8000_0204, 32'h93), "ar_accept", 0);
    // R stall 5 cycles, then data accepted.
    for (int i = 0; i < 5; i++)
      step(mk(0,0,0,32'h0,2'd0,1,0,0,32'h0, C_R, 32'h8000_0204, 32'h93), "r_stall", i);
    step(mk(0,0,1,32'h00A0_0093,2'd0,0,0,0,32'h0, C_R, 32'h8000_0204, 32'h93), "r_accept", 0);

    // Decode stalls 4 cycles; stray rvalid and commit requests are ignored.
    for (int i = 0; i < 4; i++)
      step(mk(0,1,1,32'h0BAD_0BAD,2'd0,0,1,1,32'h0, C_V, 32'h8000_0204, 32'h00A0_0093), "hold_stall", i);
    step(mk(0,0,0,32'h0,2'd0,1,0,0,32'h0, C_V, 32'h8000_0204, 32'h00A0_0093), "hold_accept", 0);
    for (int i = 0; i < 2; i++)
      step(mk(0,0,0,32'h0,2'd0,1,0,0,32'h0, C_IDLE, 32'h8000_0204, 32'h00A0_0093), "exec_wait", i);
    step(mk(0,0,0,32'h0,2'd0,1,1,0,32'h0, C_IDLE, 32'h8000_0204, 32'h00A0_0093), "exec_commit", 0);

    // Reset while in RESP with rvalid pending; the beat must be dropped.
    step(mk(0,1,0,32'h0,2'd0,1,0,0,32'h0, C_AR, 32'h8000_0208, 32'h00A0_0093), "pre_rst_ar", 0);
    step(mk(1,0,1,32'h1111_1111,2'd0,1,0,0,32'h0, C_R, 32'h8000_0208, 32'h00A0_0093), "rst_in_resp", 0);
    step(mk(0,0,1,32'h1111_1111,2'd0,1,0,0,32'h0, C_IDLE, 32'h8000_0000, 32'h0), "post_rst", 0);
    step(mk(0,1,0,32'h0,2'd0,1,0,0,32'h0, C_AR, 32'h8000_0000, 32'h0), "post_rst_ar", 0);
    step(mk(0,1,1,32'h93,2'd0,1,0,0,32'h0, C_R, 32'h8000_0000, 32'h0), "post_rst_r", 0);
    step(mk(0,1,1,32'h93,2'd0,1,0,0,32'h0, C_V, 32'h8000_0000, 32'h93), "post_rst_v", 0);

    // Jump to the top word, then a sequential commit must wrap to 0.
    step(mk(0,1,1,32'h93,2'd0,1,1,1,32'hFFFF_FFFC, C_IDLE, 32'h8000_0000, 32'h93), "jump_top", 0);
    step(mk(0,1,1,32'h93,2'd0,1,0,0,32'h0, C_AR,   32'hFFFF_FFFC, 32'h93), "wrap_ar", 0);
    step(mk(0,1,1,32'h93,2'd0,1,0,0,32'h0, C_R,    32'hFFFF_FFFC, 32'h93), "wrap_r", 0);
    step(mk(0,1,1,32'h93,2'd0,1,0,0,32'h0, C_V,    32'hFFFF_FFFC, 32'h93), "wrap_v", 0);
    step(mk(0,1,1,32'h93,2'd0,1,1,0,32'h0, C_IDLE, 32'hFFFF_FFFC, 32'h93), "wrap_commit", 0);
    step(mk(0,1,1,32'h93,2'd0,1,0,0,32'h0, C_AR,   32'h0000_0000, 32'h93), "wrap_next", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
